// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared constants, pixel-mode enum and palette slice helper for
//           the VGA pixel datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int WORD_W            = 32;
  localparam int RGB_W             = 6;
  localparam int PAL_ENTRIES       = 4;
  localparam int PAL_W             = RGB_W * PAL_ENTRIES;
  localparam int PIX_PER_WORD_1BPP = 32;
  localparam int PIX_PER_WORD_2BPP = 16;
  // Must hold the value 32, hence one bit wider than log2(32).
  localparam int PIX_CNT_W         = 6;

  typedef enum logic {
    BPP_1 = 1'b0,
    BPP_2 = 1'b1
  } bpp_mode_e;

  function automatic logic [RGB_W-1:0] pal_entry(
    input logic [PAL_W-1:0] pal,
    input logic [1:0]       idx
  );
    return pal[idx*RGB_W +: RGB_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_palette_mux.sv
// ============================================================================
// Module  : vga_palette_mux
// Purpose : Combinational 4-entry RGB222 palette lookup.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_palette_mux
  import vga_pkg::*;
(
  input  logic [1:0]       index,
  input  logic [PAL_W-1:0] palette,
  output logic [RGB_W-1:0] rgb
);

  always_comb begin
    rgb = pal_entry(palette, index);
  end

endmodule

`default_nettype wire

// File: rtl/vga_pixel_shifter.sv
// ============================================================================
// Module  : vga_pixel_shifter
// Purpose : Staging buffer, 1/2 bpp pixel shifter with horizontal scaling and
//           palette, registered RGB222 and syncs. Optional underrun episode
//           counter enabled by VGA_UNDERRUN_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pixel_shifter
  import vga_pkg::*;
#(
  parameter int WORD_W  = 32,
  parameter int SCALE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blank_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [WORD_W-1:0]  data_in,
  input  logic               data_we,
  output logic               data_req,
  input  logic               flush,
  input  logic               bpp2,
  input  logic [SCALE_W-1:0] scale,
  input  logic [23:0]        palette,
  input  logic               underrun_clr,
  output logic               underrun,
  output logic [5:0]         rgb,
  output logic               hsync_out,
  output logic               vsync_out
`ifdef VGA_UNDERRUN_COUNT_EN
  ,
  output logic [7:0]         underrun_count
`endif
);

  logic [WORD_W-1:0]    staging_q, staging_d;
  logic                 staging_valid_q, staging_valid_d;
  logic [WORD_W-1:0]    shift_q, shift_d;
  logic [PIX_CNT_W-1:0] pixels_left_q, pixels_left_d;
  bpp_mode_e            mode_q, mode_d;
  logic [SCALE_W-1:0]   scale_cnt_q, scale_cnt_d;
  logic [SCALE_W-1:0]   scale_q, scale_d;
  logic [RGB_W-1:0]     rgb_q, rgb_d;
  logic                 hsync_q, vsync_q;
  logic                 underrun_q, underrun_d;

  logic                 active;
  logic                 avail;
  logic                 empty;
  logic                 pix_end;
  logic                 drain_last;
  logic                 load;
  logic                 starved;
  logic [WORD_W-1:0]    load_word;
  logic [1:0]           pix_idx;
  logic [RGB_W-1:0]     pal_rgb;

  always_comb begin
    active     = !blank_in;
    avail      = staging_valid_q | data_we;
    empty      = (pixels_left_q == '0);
    pix_end    = (scale_cnt_q == scale_q);
    // Reloading on the final clock of the last pixel keeps words seamless.
    drain_last = active && !empty && pix_end && (pixels_left_q == PIX_CNT_W'(1));
    load       = avail && (empty || drain_last) && !flush;
    starved    = active && empty && !avail;
    load_word  = staging_valid_q ? staging_q : data_in;
    pix_idx    = (mode_q == BPP_2) ? shift_q[1:0] : {1'b0, shift_q[0]};
  end

  vga_palette_mux u_palette_mux (
    .index   (pix_idx),
    .palette (palette),
    .rgb     (pal_rgb)
  );

  always_comb begin
    staging_d       = staging_q;
    staging_valid_d = staging_valid_q;
    shift_d         = shift_q;
    pixels_left_d   = pixels_left_q;
    mode_d          = mode_q;
    scale_cnt_d     = '0;
    scale_d         = blank_in ? scale : scale_q;
    rgb_d           = '0;
    underrun_d      = underrun_q;

    if (active && !empty) begin
      rgb_d = pal_rgb;
      if (pix_end) begin
        shift_d       = (mode_q == BPP_2) ? (shift_q >> 2) : (shift_q >> 1);
        pixels_left_d = pixels_left_q - PIX_CNT_W'(1);
      end else begin
        scale_cnt_d = scale_cnt_q + SCALE_W'(1);
      end
    end

    if (load) begin
      shift_d       = load_word;
      mode_d        = bpp2 ? BPP_2 : BPP_1;
      pixels_left_d = bpp2 ? PIX_CNT_W'(PIX_PER_WORD_2BPP)
                           : PIX_CNT_W'(PIX_PER_WORD_1BPP);
      scale_cnt_d   = '0;
    end

    if (load && staging_valid_q) begin
      staging_valid_d = data_we;
      if (data_we) begin
        staging_d = data_in;
      end
    end else if (data_we && !load) begin
      staging_d       = data_in;
      staging_valid_d = 1'b1;
    end

    if (flush) begin
      pixels_left_d   = '0;
      staging_valid_d = 1'b0;
      scale_cnt_d     = '0;
    end

    if (starved) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      staging_q       <= '0;
      staging_valid_q <= 1'b0;
      shift_q         <= '0;
      pixels_left_q   <= '0;
      mode_q          <= BPP_1;
      scale_cnt_q     <= '0;
      scale_q         <= '0;
      rgb_q           <= '0;
      hsync_q         <= 1'b0;
      vsync_q         <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      staging_q       <= staging_d;
      staging_valid_q <= staging_valid_d;
      shift_q         <= shift_d;
      pixels_left_q   <= pixels_left_d;
      mode_q          <= mode_d;
      scale_cnt_q     <= scale_cnt_d;
      scale_q         <= scale_d;
      rgb_q           <= rgb_d;
      hsync_q         <= hsync_in;
      vsync_q         <= vsync_in;
      underrun_q      <= underrun_d;
    end
  end

`ifdef VGA_UNDERRUN_COUNT_EN
  logic       starved_q;
  logic [7:0] urun_cnt_q, urun_cnt_d;

  always_comb begin
    urun_cnt_d = urun_cnt_q;
    if (underrun_clr) begin
      urun_cnt_d = '0;
    end else if (starved && !starved_q && (urun_cnt_q != 8'hFF)) begin
      urun_cnt_d = urun_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starved_q  <= 1'b0;
      urun_cnt_q <= '0;
    end else begin
      starved_q  <= starved;
      urun_cnt_q <= urun_cnt_d;
    end
  end

  assign underrun_count = urun_cnt_q;
`endif

  assign data_req  = !staging_valid_q;
  assign underrun  = underrun_q;
  assign rgb       = rgb_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

endmodule

`default_nettype wire
